// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-control encodings, FSM states and default vectors
package cpu_pkg;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_LOAD = 2'b01;
  localparam logic [1:0] PC_HOLD = 2'b10;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEFAULT  = 32'h0000_0100;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencer arbitrating boot, trap, branch, stall and halt
// Drives fetch_stage PC_op/PC_in combinationally and owns the wrong-path flush window.
module fetch_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        resume,
  output logic [1:0]  PC_op,
  output logic [31:0] PC_in,
  output logic        fetch_valid,
  output logic        flush,
  output logic        halted,
  output logic [15:0] redirect_count
);

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  fetch_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [15:0]  redirect_count_q, redirect_count_d;
  logic         redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_BOOT;
      cnt_q            <= '0;
      redirect_count_q <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PC_op       = PC_INC;
    PC_in       = '0;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    redirect    = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        PC_op   = PC_LOAD;
        PC_in   = RESET_VECTOR;
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_INIT;
      end
      ST_RUN, ST_FLUSH: begin
        fetch_valid = (state_q == ST_RUN);
        if (trap_req || branch_taken) begin
          // Trap outranks branch; either reopens a full flush window.
          PC_op    = PC_LOAD;
          PC_in    = trap_req ? TRAP_VECTOR : (branch_target & ~32'h3);
          redirect = 1'b1;
          state_d  = ST_FLUSH;
          cnt_d    = FLUSH_INIT;
        end else if (state_q == ST_RUN && halt_req) begin
          PC_op   = PC_HOLD;
          state_d = ST_HALTED;
        end else if (stall_req) begin
          PC_op = PC_HOLD;
        end else if (state_q == ST_FLUSH) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_HALTED: begin
        halted = 1'b1;
        PC_op  = PC_HOLD;
        if (trap_req) begin
          PC_op    = PC_LOAD;
          PC_in    = TRAP_VECTOR;
          redirect = 1'b1;
          state_d  = ST_FLUSH;
          cnt_d    = FLUSH_INIT;
        end else if (resume) begin
          PC_op   = PC_INC;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    redirect_count_d = redirect_count_q;
    if (redirect && redirect_count_q != 16'hFFFF) begin
      redirect_count_d = redirect_count_q + 16'd1;
    end
  end

  assign flush          = redirect;
  assign redirect_count = redirect_count_q;

endmodule
